// File: rtl/ch_beacon_tx.sv
// Cluster-head beacon transmitter: emits a 6-byte advertisement (type, id, q, hops, xor) on a timer or trigger.
// Optional BEACON_JITTER_EN adds 0..15 cycles of LFSR jitter to every timer reload.
module ch_beacon_tx #(
  parameter int         PERIOD_W = 16,
  parameter logic [7:0] PKT_TYPE = 8'hC1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic                role_is_ch,
  input  logic [7:0]          my_id,
  input  logic [15:0]         my_q,
  input  logic [7:0]          my_hops,
  input  logic [PERIOD_W-1:0] period,
  input  logic                trigger,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                tx_last,
  output logic                busy,
  output logic [15:0]         beacon_cnt
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state, stateNext;
  logic [2:0]          idx, idxNext;
  logic                pending, pendingNext;
  logic [15:0]         cntNext;
  logic                startPkt;
  logic [7:0]          idSnap, qHiSnap, qLoSnap, hopsSnap, csumSnap;
  logic                active, activeDly, activeRise, expire, request;
  logic [PERIOD_W-1:0] timer, periodM1, reloadVal;

  assign active     = en && role_is_ch;
  assign activeRise = active && !activeDly;
  assign periodM1   = period - PERIOD_W'(1);
  // The timer sits at 0 while inactive, so the rising-edge cycle must not count as an expiry.
  assign expire     = active && !activeRise && (period != '0) && (timer == '0);
  assign request    = expire || (trigger && active);

`ifdef BEACON_JITTER_EN
  logic [7:0]        lfsr;
  logic              seeded;
  logic [PERIOD_W:0] jitSum;

  // Seeded from my_id on the first cycle after reset release so neighbours diverge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lfsr   <= 8'h00;
      seeded <= 1'b0;
    end else if (!seeded) begin
      lfsr   <= my_id | 8'h01;
      seeded <= 1'b1;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign jitSum    = {1'b0, periodM1} + {{(PERIOD_W - 3){1'b0}}, lfsr[3:0]};
  assign reloadVal = jitSum[PERIOD_W] ? {PERIOD_W{1'b1}} : jitSum[PERIOD_W-1:0];
`else
  assign reloadVal = periodM1;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      activeDly <= 1'b0;
      timer     <= '0;
    end else begin
      activeDly <= active;
      if (!active) begin
        timer <= '0;
      end else if (activeRise) begin
        timer <= (period == '0) ? '0 : reloadVal;
      end else if (period != '0) begin
        timer <= (timer == '0) ? reloadVal : timer - PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      idx        <= 3'd0;
      pending    <= 1'b0;
      beacon_cnt <= 16'd0;
    end else begin
      state      <= stateNext;
      idx        <= idxNext;
      pending    <= pendingNext;
      beacon_cnt <= cntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    idxNext     = idx;
    pendingNext = pending;
    cntNext     = beacon_cnt;
    startPkt    = 1'b0;
    case (state)
      IDLE: begin
        if (active && (request || pending)) begin
          stateNext   = SEND;
          idxNext     = 3'd0;
          pendingNext = 1'b0;
          startPkt    = 1'b1;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx == 3'd5) begin
            cntNext = beacon_cnt + 16'd1;
            idxNext = 3'd0;
            // Back-to-back restart keeps tx_valid high with no idle cycle.
            if (active && (request || pending)) begin
              pendingNext = 1'b0;
              startPkt    = 1'b1;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            idxNext = idx + 3'd1;
          end
        end
        if (request && !startPkt) pendingNext = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
    if (!active) pendingNext = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idSnap   <= 8'h00;
      qHiSnap  <= 8'h00;
      qLoSnap  <= 8'h00;
      hopsSnap <= 8'h00;
      csumSnap <= 8'h00;
    end else if (startPkt) begin
      idSnap   <= my_id;
      qHiSnap  <= my_q[15:8];
      qLoSnap  <= my_q[7:0];
      hopsSnap <= my_hops;
      csumSnap <= PKT_TYPE ^ my_id ^ my_q[15:8] ^ my_q[7:0] ^ my_hops;
    end
  end

  always_comb begin
    tx_valid = (state == SEND);
    busy     = tx_valid;
    tx_last  = tx_valid && (idx == 3'd5);
    tx_data  = 8'h00;
    if (state == SEND) begin
      case (idx)
        3'd0:    tx_data = PKT_TYPE;
        3'd1:    tx_data = idSnap;
        3'd2:    tx_data = qHiSnap;
        3'd3:    tx_data = qLoSnap;
        3'd4:    tx_data = hopsSnap;
        default: tx_data = csumSnap;
      endcase
    end
  end

endmodule

// File: tb/tb_ch_beacon_tx.sv
// Self-checking bench for ch_beacon_tx: directed scenarios plus randomized fields and back-pressure.
module tb_ch_beacon_tx;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en, role_is_ch, trigger, tx_ready;
  logic [7:0]  my_id, my_hops;
  logic [15:0] my_q;
  logic [15:0] period;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last, busy;
  logic [15:0] beacon_cnt;

  ch_beacon_tx dut (
    .clk(clk), .nrst(nrst), .en(en), .role_is_ch(role_is_ch),
    .my_id(my_id), .my_q(my_q), .my_hops(my_hops), .period(period),
    .trigger(trigger), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy), .beacon_cnt(beacon_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       last;
    logic [7:0] data;
  } hs_t;

  hs_t  hsQ[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   protoErr = 0;
  logic prevValid = 1'b0, prevStall = 1'b0, prevHsLast = 1'b0, prevLast = 1'b0;
  logic [7:0] prevData = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol observer: records every accepted byte and flags stability/drop violations.
  always @(negedge clk) begin
    if (!nrst) begin
      prevValid = 1'b0; prevStall = 1'b0; prevHsLast = 1'b0;
    end else begin
      if (busy !== tx_valid) protoErr++;
      if (prevValid && !prevHsLast && !tx_valid) protoErr++;
      if (prevStall && (tx_valid !== 1'b1 || tx_data !== prevData || tx_last !== prevLast)) protoErr++;
      if (tx_valid && tx_ready) hsQ.push_back('{cyc: cyc, last: tx_last, data: tx_data});
      prevValid  = tx_valid;
      prevStall  = tx_valid && !tx_ready;
      prevHsLast = tx_valid && tx_ready && tx_last;
      prevData   = tx_data;
      prevLast   = tx_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference packet: header fields followed by the XOR of everything before it.
  function automatic logic [47:0] refPkt(input logic [7:0] id, input logic [15:0] q, input logic [7:0] hops);
    logic [7:0] b[5];
    logic [7:0] x;
    logic [47:0] p;
    b[0] = 8'hC1; b[1] = id; b[2] = q[15:8]; b[3] = q[7:0]; b[4] = hops;
    x = 8'h00;
    p = '0;
    for (int i = 0; i < 5; i++) begin
      x = x ^ b[i];
      p = {p[39:0], b[i]};
    end
    return {p[39:0], x};
  endfunction

  task automatic checkPacket(input string tag, input logic [7:0] id, input logic [15:0] q,
                             input logic [7:0] hops, output int startCyc);
    int n;
    logic [47:0] got;
    logic [5:0]  lasts;
    hs_t e;
    n = 0;
    startCyc = -1;
    while (hsQ.size() < 6 && n < 3000) begin tick(1); n++; end
    chk({tag, "_arrived"}, 64'(hsQ.size() >= 6), 64'd1);
    if (hsQ.size() >= 6) begin
      got = '0; lasts = '0;
      for (int i = 0; i < 6; i++) begin
        e = hsQ.pop_front();
        if (i == 0) startCyc = e.cyc;
        got   = {got[39:0], e.data};
        lasts = {lasts[4:0], e.last};
      end
      chk({tag, "_bytes"}, 64'(got), 64'(refPkt(id, q, hops)));
      chk({tag, "_last"}, 64'(lasts), 64'(6'b000001));
    end
  endtask

  initial begin
    int r, t, s, prevS, n;
    logic [7:0]  fid, fh;
    logic [15:0] fq;

    nrst = 1'b0; en = 1'b0; role_is_ch = 1'b0; trigger = 1'b0; tx_ready = 1'b1;
    my_id = 8'h00; my_q = 16'h0000; my_hops = 8'h00; period = 16'd0;
    tick(2);
    chk("reset_outputs", 64'({tx_valid, busy, tx_last, tx_data, beacon_cnt}), 64'd0);
    nrst = 1'b1;
    tick(2);

    // Periodic beacons, no back-pressure.
    my_id = 8'h05; my_q = 16'h1234; my_hops = 8'h02; period = 16'd100;
    en = 1'b1; role_is_ch = 1'b1;
    r = cyc; prevS = 0;
    for (int k = 0; k < 3; k++) begin
      checkPacket("periodic", 8'h05, 16'h1234, 8'h02, s);
      chk("periodic_cnt", 64'(beacon_cnt), 64'(k + 1));
`ifdef BEACON_JITTER_EN
      if (k == 0) chk("first_start_range", 64'(s >= r + 101 && s <= r + 116), 64'd1);
      else        chk("interval_range", 64'(s - prevS >= 100 && s - prevS <= 115), 64'd1);
`else
      if (k == 0) chk("first_start", 64'(s), 64'(r + 101));
      else        chk("interval", 64'(s - prevS), 64'd100);
`endif
      prevS = s;
    end
    period = 16'd0;
    tick(5);

    // Back-pressure at byte 2.
    fid = 8'($urandom); fq = 16'($urandom); fh = 8'($urandom);
    my_id = fid; my_q = fq; my_hops = fh;
    trigger = 1'b1; t = cyc;
    tick(1); trigger = 1'b0;
    tick(2); tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold", 64'({tx_valid, busy, tx_data}), 64'({1'b1, 1'b1, fq[15:8]}));
      tick(1);
    end
    tx_ready = 1'b1;
    checkPacket("backpressure", fid, fq, fh, s);
    chk("bp_start", 64'(s), 64'(t + 1));
    chk("bp_cnt", 64'(beacon_cnt), 64'd4);

    // Coalescing of three triggers plus mid-packet field change.
    my_id = 8'h05; my_q = 16'h1234; my_hops = 8'h02;
    trigger = 1'b1; t = cyc;
    tick(1); trigger = 1'b1;
    tick(1); trigger = 1'b0; my_q = 16'hABCD;
    tick(1); trigger = 1'b1;
    tick(1); trigger = 1'b0;
    tick(1); trigger = 1'b1;
    tick(1); trigger = 1'b0;
    checkPacket("snap_old", 8'h05, 16'h1234, 8'h02, prevS);
    checkPacket("snap_new", 8'h05, 16'hABCD, 8'h02, s);
    chk("coalesce_start", 64'(prevS), 64'(t + 1));
    chk("coalesce_nogap", 64'(s), 64'(prevS + 6));
    chk("coalesce_cnt", 64'(beacon_cnt), 64'd6);
    tick(60);
    chk("coalesce_single", 64'(hsQ.size()), 64'd0);

    // Role drop mid-packet with a pending request.
    fid = 8'($urandom); fq = 16'($urandom); fh = 8'($urandom);
    my_id = fid; my_q = fq; my_hops = fh;
    role_is_ch = 1'b0; tick(1);
    role_is_ch = 1'b1; period = 16'd100;
    n = 0;
    while (!tx_valid && n < 300) begin tick(1); n++; end
    chk("drop_first_beacon", 64'(tx_valid), 64'd1);
    trigger = 1'b1; tick(1); trigger = 1'b0;
    tick(2); role_is_ch = 1'b0;
    checkPacket("role_drop", fid, fq, fh, s);
    chk("drop_cnt", 64'(beacon_cnt), 64'd7);
    tick(250);
    chk("drop_silent", 64'({busy, 32'(hsQ.size())}), 64'd0);

    // Reset asserted mid-packet.
    role_is_ch = 1'b1; period = 16'd0;
    tick(2);
    trigger = 1'b1; tick(1); trigger = 1'b0;
    tick(3);
    chk("pre_reset_valid", 64'(tx_valid), 64'd1);
    nrst = 1'b0;
    #1;
    chk("async_reset", 64'({tx_valid, busy, beacon_cnt}), 64'd0);
    tick(2);
    hsQ.delete();
    nrst = 1'b1;
    tick(3);
    chk("post_reset_cnt", 64'(beacon_cnt), 64'd0);

    // period=0: a trigger sends exactly one beacon.
    fid = 8'($urandom); fq = 16'($urandom); fh = 8'($urandom);
    my_id = fid; my_q = fq; my_hops = fh;
    trigger = 1'b1; t = cyc;
    tick(1); trigger = 1'b0;
    checkPacket("oneshot", fid, fq, fh, s);
    chk("oneshot_start", 64'(s), 64'(t + 1));
    tick(1000);
    chk("oneshot_only", 64'({beacon_cnt, 32'(hsQ.size())}), 64'({16'd1, 32'd0}));

    // Randomized fields under random back-pressure.
    for (int k = 0; k < 4; k++) begin
      fid = 8'($urandom); fq = 16'($urandom); fh = 8'($urandom);
      my_id = fid; my_q = fq; my_hops = fh;
      trigger = 1'b1; tick(1); trigger = 1'b0;
      n = 0;
      while (hsQ.size() < 6 && n < 300) begin
        tx_ready = 1'($urandom_range(0, 1));
        tick(1); n++;
      end
      tx_ready = 1'b1;
      checkPacket("random", fid, fq, fh, s);
      chk("random_cnt", 64'(beacon_cnt), 64'(k + 2));
      tick(3);
    end

    chk("protocol_rules", 64'(protoErr), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ch_beacon_tx.md
Name: ch_beacon_tx

Overview:
- Cluster-head side of the CH advertisement protocol.
- When the node holds the CH role, it periodically (or on demand) emits a 6-byte beacon carrying its ID, Q-value and hop count.
- Member nodes receive these beacons and feed them to their CH selection logic, which picks min hops, then max Q, then min ID.
- Sits between the RL/role controller and the radio MAC byte interface.

Parameters:
- PERIOD_W, 16, width of the beacon period counter.
- PKT_TYPE, 8'hC1, beacon type byte.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  beacon engine enable
- role_is_ch  in  1  node currently holds the cluster-head role
- my_id  in  8  own CH_ID
- my_q  in  16  own Q-value
- my_hops  in  8  own hop count to sink
- period  in  PERIOD_W  cycles between periodic beacons; 0 disables the timer
- trigger  in  1  one-cycle request for an immediate beacon
- tx_data  out  8  beacon byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  MAC accepts byte
- tx_last  out  1  final byte of beacon
- busy  out  1  packet in flight
- beacon_cnt  out  16  completed beacons, wraps at 16'hFFFF->0

Behaviour:
- Reset (async, nrst=0): all outputs 0, FSM=IDLE, timer=0, pending=0, snapshot regs=0.
- Active = en && role_is_ch.
- Timer:
  - On the rising edge of active, the timer loads period-1.
  - While active and period!=0, it decrements each cycle. At 0 it raises a request and reloads period-1.
  - A new period value takes effect at the next reload.
  - When not active, the timer holds at 0 and requests are suppressed.
- Request = timer expiry OR (trigger && active).
  - Requests arriving while busy set a single pending flag; multiple requests coalesce into one.
  - Pending is serviced on the cycle after the tx_last handshake.
- FSM states:
  - IDLE: on a request (or pending), snapshot my_id/my_q/my_hops, compute the checksum, go to SEND with idx=0.
    - Request at cycle N -> tx_valid=1 with byte0 at N+1.
  - SEND: tx_valid=1 and tx_data=byte[idx].
    - On tx_valid&&tx_ready: idx++.
    - On idx 5 handshake: beacon_cnt++ and go to IDLE. If pending (and still active), clear pending and restart directly, so tx_valid stays high with no idle cycle.
- Packet bytes:
  - 0 = PKT_TYPE
  - 1 = id
  - 2 = q[15:8]
  - 3 = q[7:0]
  - 4 = hops
  - 5 = XOR of bytes 0-4
  - tx_last=1 only on byte 5.
- Handshake rules:
  - While tx_valid && !tx_ready, tx_data and tx_last hold stable and tx_valid stays 1.
  - tx_valid never drops mid-packet.
- Fields are sampled at packet start only; input changes mid-packet do not affect the packet in flight.
- busy=1 from the cycle tx_valid rises through the tx_last handshake cycle.
- Deasserting active mid-packet: the current packet completes untruncated; pending is cleared; no further beacons are sent.
- trigger with period=0: sends exactly one beacon.
- Simultaneous timer expiry and trigger: one beacon.
- nrst asserted mid-packet: immediate abort; tx_valid=0 asynchronously.

Optional Feature:
- Macro: BEACON_JITTER_EN.
- Defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed = my_id | 8'h01 at reset release) advances every clk.
  - At each reload, 4 LSBs of the LFSR (0..15) are added to period-1, de-synchronising neighbouring CHs.
  - The add saturates at all-ones PERIOD_W.
  - trigger latency is unchanged.
- Undefined: the reload is exactly period-1, giving exact periodicity. No LFSR logic is present.

Test Plan:
- Periodic, no back-pressure: id=0x05, q=0x1234, hops=0x02, period=100, tx_ready=1 -> bytes C1,05,12,34,02,E0 with tx_last on E0. Beacons start every 100 cycles; beacon_cnt=1,2,3.
- Back-pressure: tx_ready low for 3 cycles at byte 2 -> tx_data holds 0x12 and tx_valid stays 1. The sequence completes intact; busy spans the whole packet.
- Coalescing: three trigger pulses during one packet -> exactly one extra beacon, starting the cycle after the tx_last handshake with no gap. beacon_cnt +2 total.
- Snapshot: change my_q to 0xABCD while byte 1 is outstanding -> current packet still carries 12,34 with checksum E0. The next packet carries AB,CD with checksum C1^05^AB^CD^02 = 0xA0.
- Role drop / reset: role_is_ch->0 at byte 3 -> packet finishes, then no further beacons even after period elapses. Separately, nrst=0 at byte 3 -> tx_valid, busy and beacon_cnt go to 0 at once.
- period=0 with trigger -> single beacon at trigger+1 and no periodic beacons for 1000 cycles. Under BEACON_JITTER_EN with period=100, measured intervals fall in [100,115].
